// File: rtl/aes256_dec_core.sv
// aes256_dec_core: iterative AES-256 inverse cipher.
// One round takes 18 cycles: InvShiftRows (1), byte-serial InvSubBytes through
// an external inverse S-box (16), AddRoundKey + InvMixColumns (1).
// Round keys come from an external key store addressed by rk_idx.
// Optional feature: define AES_DEC_FLUSH_EN to add a synchronous 'flush' input
// that aborts any operation and returns the core to IDLE.
module aes256_dec_core #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         resetn,
`ifdef AES_DEC_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [7:0]   isb_addr,
  input  logic [7:0]   isb_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  // Index of the last round key; the initial AddRoundKey uses it.
  localparam logic [3:0] LAST_KEY = 4'(NR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    SUB   = 3'd2,
    KEY   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_r, state_n;
  logic [127:0]   data_r, data_n;
  logic [3:0]     rnd_r, rnd_n;
  logic [3:0]     bcnt_r, bcnt_n;
  logic           in_ready_r, out_valid_r, busy_r;
  logic           flush_s;
  logic [127:0]   ark_s;
  logic [6:0]     byte_sh_s;

`ifdef AES_DEC_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] gf_x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(gf_x2(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    return gf_x2(gf_x2(gf_x2(a))) ^ gf_x2(gf_x2(a)) ^ gf_x2(a);
  endfunction

  // Row r of the 4x4 byte matrix is rotated right by r positions.
  // Byte i of the block lives at row i%4, column i/4, MSB-first.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127 - 8 * (rw + 4 * c) -: 8] = s[127 - 8 * (rw + 4 * ((c - rw + 4) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  // Each column is multiplied by the circulant matrix {0e,0b,0d,09}.
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = 128'd0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      r[127 - 32 * c -: 8] = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
      r[119 - 32 * c -: 8] = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
      r[111 - 32 * c -: 8] = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
      r[103 - 32 * c -: 8] = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
    end
    return r;
  endfunction

  // Bit offset of byte bcnt from the LSB: (15 - bcnt) * 8.
  assign byte_sh_s = {~bcnt_r, 3'b000};
  assign ark_s     = data_r ^ rk_data;

  // Next-state, datapath and counter logic for the round FSM.
  always_comb begin
    state_n = state_r;
    data_n  = data_r;
    rnd_n   = rnd_r;
    bcnt_n  = bcnt_r;
    if (flush_s) begin
      state_n = IDLE;
      data_n  = 128'd0;
      rnd_n   = 4'd0;
      bcnt_n  = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            data_n  = in_data ^ rk_data;
            rnd_n   = LAST_KEY - 4'd1;
            state_n = SHIFT;
          end else begin
            state_n = IDLE;
          end
        end
        SHIFT: begin
          data_n  = inv_shift_rows(data_r);
          bcnt_n  = 4'd0;
          state_n = SUB;
        end
        SUB: begin
          data_n = (data_r & ~(128'hff << byte_sh_s)) | ({120'd0, isb_data} << byte_sh_s);
          bcnt_n = bcnt_r + 4'd1;
          if (bcnt_r == 4'd15) begin
            state_n = KEY;
          end else begin
            state_n = SUB;
          end
        end
        KEY: begin
          if (rnd_r == 4'd0) begin
            data_n  = ark_s;
            state_n = DONE;
          end else begin
            data_n  = inv_mix_columns(ark_s);
            rnd_n   = rnd_r - 4'd1;
            state_n = SHIFT;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_n = IDLE;
          end else begin
            state_n = DONE;
          end
        end
        default: begin
          state_n = IDLE;
          data_n  = 128'd0;
          rnd_n   = 4'd0;
          bcnt_n  = 4'd0;
        end
      endcase
    end
  end

  // State, datapath and handshake flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      data_r      <= 128'd0;
      rnd_r       <= 4'd0;
      bcnt_r      <= 4'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      data_r      <= data_n;
      rnd_r       <= rnd_n;
      bcnt_r      <= bcnt_n;
      in_ready_r  <= (state_n == IDLE);
      out_valid_r <= (state_n == DONE);
      busy_r      <= (state_n != IDLE);
    end
  end

  // Key-store and S-box addressing decoded from the current state.
  always_comb begin
    rk_idx   = LAST_KEY;
    isb_addr = 8'd0;
    case (state_r)
      SHIFT, KEY: begin
        rk_idx = rnd_r;
      end
      SUB: begin
        rk_idx   = rnd_r;
        isb_addr = 8'(data_r >> byte_sh_s);
      end
      default: begin
        rk_idx   = LAST_KEY;
        isb_addr = 8'd0;
      end
    endcase
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = data_r;

endmodule

// File: tb/tb_aes256_dec_core.sv
// Directed bench for aes256_dec_core: a behavioural key store and inverse
// S-box feed the core; expected data come from FIPS-197 constants and from an
// independent byte-array AES-256 model.
module tb_aes256_dec_core;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [7:0]   isb_addr;
  logic [7:0]   isb_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_DEC_FLUSH_EN
  logic         flush;
`endif

  logic [7:0]   sbox     [0:255];
  logic [7:0]   inv_sbox [0:255];
  logic [127:0] rk_tab   [0:15];
  logic [7:0]   exp_addr [0:251];
  logic [3:0]   exp_rk   [0:251];

  int checks   = 0;
  int failures = 0;

  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_C3  = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    bit           use_model;
  } vec_t;

  aes256_dec_core #(.NR(14)) dut (
    .clk      (clk),
    .resetn   (resetn),
`ifdef AES_DEC_FLUSH_EN
    .flush    (flush),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .isb_addr (isb_addr),
    .isb_data (isb_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  assign rk_data  = rk_tab[rk_idx];
  assign isb_data = inv_sbox[isb_addr];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'd0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sboxes();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'd0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic set_key(input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i - 1];
      if (i % 8 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'd0};
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - 8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_tab[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    rk_tab[15] = 128'd0;
  endtask

  // Byte-array inverse cipher; also records the expected per-cycle isb_addr / rk_idx.
  task automatic model_dec(input logic [127:0] ct, output logic [127:0] pt);
    logic [7:0] s [0:15];
    logic [7:0] t [0:15];
    logic [7:0] k [0:15];
    int rnd, base;
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8 * i -: 8] ^ rk_tab[14][127 - 8 * i -: 8];
    for (int j = 0; j < 14; j++) begin
      rnd  = 13 - j;
      base = 18 * j;
      for (int p = 0; p < 18; p++) exp_rk[base + p] = 4'(rnd);
      exp_addr[base]      = 8'd0;
      exp_addr[base + 17] = 8'd0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r + 4 * ((c + r) % 4)] = s[r + 4 * c];
      for (int i = 0; i < 16; i++) begin
        exp_addr[base + 1 + i] = t[i];
        k[i] = rk_tab[rnd][127 - 8 * i -: 8];
        s[i] = inv_sbox[t[i]] ^ k[i];
      end
      if (rnd != 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            t[r + 4 * c] = gmul(8'h0e, s[4 * c + r]) ^ gmul(8'h0b, s[4 * c + (r + 1) % 4]) ^
                           gmul(8'h0d, s[4 * c + (r + 2) % 4]) ^ gmul(8'h09, s[4 * c + (r + 3) % 4]);
          end
        end
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
    end
    for (int i = 0; i < 16; i++) pt[127 - 8 * i -: 8] = s[i];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called between a negedge and the next posedge; returns at the negedge after acceptance.
  task automatic accept(input logic [127:0] ct);
    in_valid = 1'b1;
    in_data  = ct;
    #1;
    chk("acc_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("acc_busy", busy, 1'b1);
  endtask

  // Follows the 252 cycles after acceptance; returns at the negedge after edge 252.
  task automatic track(input string tag, input logic [127:0] exp_pt, input bit chk_seq);
    bit early;
    early = 1'b0;
    for (int k = 0; k < 252; k++) begin
      if (out_valid !== 1'b0) early = 1'b1;
      if (chk_seq) begin
        chk({tag, "_isb_addr"}, isb_addr, exp_addr[k]);
        chk({tag, "_rk_idx"}, rk_idx, exp_rk[k]);
      end
      @(negedge clk);
    end
    chk({tag, "_early_valid"}, early, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_out_data"}, out_data, exp_pt);
    chk({tag, "_done_rk_idx"}, rk_idx, 4'd14);
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_handoff_valid"}, out_valid, 1'b0);
    chk({tag, "_handoff_ready"}, in_ready, 1'b1);
    chk({tag, "_handoff_busy"}, busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 128'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rk_idx"}, rk_idx, 4'd14);
    chk({tag, "_isb_addr"}, isb_addr, 8'd0);
  endtask

  initial begin
    vec_t         vecs [0:2];
    logic [127:0] exp_pt, c3_pt;
    bit           bad;

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 128'd0;
    out_ready = 1'b0;
`ifdef AES_DEC_FLUSH_EN
    flush     = 1'b0;
`endif
    build_sboxes();

    vecs[0] = '{key: KEY_C3, ct: CT_C3, pt: PT_C3, use_model: 1'b0};
    vecs[1] = '{key: 256'd0, ct: 128'd0, pt: 128'd0, use_model: 1'b1};
    vecs[2] = '{key: KEY_C3, ct: PT_C3, pt: 128'd0, use_model: 1'b1};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");

    // First vector is offered on the very first edge after reset release.
    resetn = 1'b1;
    for (int v = 0; v < 3; v++) begin
      set_key(vecs[v].key);
      model_dec(vecs[v].ct, exp_pt);
      if (!vecs[v].use_model) exp_pt = vecs[v].pt;
      accept(vecs[v].ct);
      track($sformatf("vec%0d", v), exp_pt, 1'b1);
      finish_out($sformatf("vec%0d", v));
    end

    set_key(KEY_C3);
    model_dec(CT_C3, c3_pt);

    // Back-pressure: 40 stalled cycles in DONE with a new block already offered.
    accept(CT_C3);
    track("bp", PT_C3, 1'b0);
    in_valid = 1'b1;
    in_data  = CT_C3;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b1 || out_data !== PT_C3 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    chk("bp_stable", bad, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_handoff_valid", out_valid, 1'b0);
    chk("bp_handoff_ready", in_ready, 1'b1);
    chk("bp_handoff_busy", busy, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accept", busy, 1'b1);
    track("bp2", PT_C3, 1'b0);
    finish_out("bp2");

    // Back-to-back with the consumer always ready.
    out_ready = 1'b1;
    accept(CT_C3);
    track("b2b1", PT_C3, 1'b0);
    in_valid = 1'b1;
    in_data  = CT_C3;
    chk("b2b_ready_in_done", in_ready, 1'b0);
    @(negedge clk);
    chk("b2b_handoff_valid", out_valid, 1'b0);
    chk("b2b_handoff_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_accept", busy, 1'b1);
    track("b2b2", PT_C3, 1'b0);
    finish_out("b2b2");

    // Reset in round 9 while byte 7 is being substituted.
    accept(CT_C3);
    repeat (80) @(negedge clk);
    chk("midrst_rk_idx", rk_idx, 4'd9);
    chk("midrst_isb_addr", isb_addr, exp_addr[80]);
    #1;
    resetn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk_reset_outputs("midrst_held");
    resetn = 1'b1;
    accept(CT_C3);
    track("postrst", PT_C3, 1'b1);
    finish_out("postrst");

`ifdef AES_DEC_FLUSH_EN
    // Flush at the start of round 5.
    accept(CT_C3);
    repeat (144) @(negedge clk);
    chk("flush_rk_before", rk_idx, 4'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_rk_idx", rk_idx, 4'd14);
    bad = 1'b0;
    repeat (5) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_valid", bad, 1'b0);
    // Flush in IDLE suppresses acceptance.
    in_valid = 1'b1;
    in_data  = CT_C3;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_idle_no_accept", busy, 1'b0);
    accept(CT_C3);
    track("flush_next", PT_C3, 1'b1);
    // Flush in DONE drops out_valid on the same edge.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_valid", out_valid, 1'b0);
    chk("flush_done_ready", in_ready, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes256_dec_core.md
AES256_DEC_CORE -- requirements
Module: aes256_dec_core

Interface
REQ-001 SHALL have parameter NR, default 14, giving the number of AES rounds; only 14 (AES-256) is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: ciphertext block offered.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepted when in_valid && in_ready at a rising edge.
REQ-006 SHALL have port in_data, input, 128 bits: ciphertext; [127:120] is byte 0, [7:0] is byte 15; byte i sits at row i%4, column i/4.
REQ-007 SHALL have port rk_idx, output, 4 bits: index of the round key requested from the external key store.
REQ-008 SHALL have port rk_data, input, 128 bits: round key rk_idx, valid combinationally in the same cycle; byte order as in_data.
REQ-009 SHALL have port isb_addr, output, 8 bits: inverse S-box lookup address.
REQ-010 SHALL have port isb_data, input, 8 bits: InvSbox(isb_addr), valid combinationally in the same cycle.
REQ-011 SHALL have port out_valid, output, 1 bit: plaintext available.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts when out_valid && out_ready at a rising edge.
REQ-013 SHALL have port out_data, output, 128 bits: plaintext, same byte order as in_data.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT, SUB, KEY and DONE, with a 4-bit round counter rnd and a 4-bit byte counter bcnt.
- IDLE: in_ready=1; rk_idx=14.
- IDLE transition: on acceptance, state <= in_data XOR rk_data, rnd <= 13, go to SHIFT.
REQ-016 In SHIFT, the block SHALL apply InvShiftRows (row r rotated right by r bytes) in one cycle, clear bcnt, and go to SUB.
REQ-017 In SUB, the block SHALL process one byte per cycle:
- drive isb_addr = state byte bcnt;
- write isb_data back to byte bcnt;
- increment bcnt;
- after bcnt=15, go to KEY.
REQ-018 In KEY, rk_idx SHALL equal rnd and state SHALL be updated to:
- (state XOR rk_data), then InvMixColumns, when rnd != 0;
- state XOR rk_data alone when rnd = 0.
REQ-019 On leaving KEY, the block SHALL go to DONE if rnd=0; otherwise it SHALL decrement rnd and go to SHIFT.
REQ-020 InvMixColumns SHALL use the matrix {0e,0b,0d,09} rotated per row, with GF(2^8) reduction polynomial 0x11B.
REQ-021 Latency SHALL be exactly 14 x 18 = 252 cycles: out_valid rises after the 252nd rising edge following the acceptance edge.
REQ-022 In DONE, out_valid SHALL be 1 and out_data SHALL equal the state register.
- out_data and out_valid SHALL hold stable while out_ready=0, for any length of stall.
- On out_valid && out_ready, go to IDLE.
REQ-023 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored, and in_data SHALL not be sampled.
- A new block SHALL be accepted no earlier than the edge after the DONE-to-IDLE transition.
REQ-024 rk_idx SHALL equal rnd in SHIFT and SUB, and 14 in IDLE and DONE.
REQ-025 isb_addr SHALL be 0 outside SUB.

Reset
REQ-026 On resetn=0, at any time including mid-round, the block SHALL immediately enter IDLE and clear the state register, rnd and bcnt.
- Outputs during reset: in_ready=1, out_valid=0, out_data=0, busy=0, rk_idx=14, isb_addr=0.
REQ-027 The first acceptance after reset deassertion SHALL be possible on the first rising edge.

Configuration
REQ-028 Macro AES_DEC_FLUSH_EN SHALL control a flush feature.
- When defined: adds input flush (1 bit). flush=1 at a rising edge SHALL return the FSM to IDLE from any state and clear state, rnd and bcnt; in that cycle acceptance SHALL be suppressed and out_valid SHALL drop on the same edge.
- When undefined: the port SHALL be absent and behaviour SHALL be as REQ-015 to REQ-025.

Verification
REQ-029 Directed scenarios (round keys driven from the bench's AES-256 key-expansion model):
- FIPS-197 C.3 vector: key 000102..1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> out_data 00112233445566778899aabbccddeeff, out_valid exactly 252 cycles after acceptance.
- Back-pressure: hold out_ready=0 for 40 cycles in DONE -> out_valid and out_data stable; a new in_valid is not accepted (in_ready=0) until one edge after out_ready=1.
- Reset mid-operation: assert resetn=0 while bcnt=7 and rnd=9 -> outputs at the REQ-026 values immediately; a subsequent C.3 run decrypts correctly.
- Back-to-back: two C.3 blocks with out_ready=1 constantly -> second acceptance occurs 1 cycle after the first DONE hand-off; both outputs correct.
- All-zero key and ciphertext 00..00 -> out_data equal to the bench model result; isb_addr sequence matches the model byte order.
- AES_DEC_FLUSH_EN defined: flush at rnd=5 -> IDLE next cycle, no out_valid; the next block decrypts correctly.
